// File: rtl/command_decoder_of_verifla_pkg.sv
// ---------------------------------------------------------------------------
// command_decoder_of_verifla_pkg
// Shared definitions for the host command decoder of the logic analyser:
//   - opcode values understood when the decoder is idle
//   - FSM state encoding for the frame collector
//   - helper to size the data-byte counter
// ---------------------------------------------------------------------------
package command_decoder_of_verifla_pkg;

   // Opcodes recognised as the first byte of a command
   localparam logic [7:0] CMD_RESET     = 8'h00;
   localparam logic [7:0] CMD_RUN       = 8'h01;
   localparam logic [7:0] CMD_WRITE_REG = 8'h02;

   // Decoder states: waiting for an opcode, then the address byte of a
   // WRITE_REG frame, then its little-endian data bytes
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GET_ADDR = 2'd1,
      GET_DATA = 2'd2
   } dec_state_t;

   // A single data byte still needs a 1-bit counter
   function automatic int byte_cnt_bits(input int n_bytes);
      return (n_bytes > 1) ? $clog2(n_bytes) : 1;
   endfunction

endpackage

// File: rtl/single_pulse_of_verifla.sv
// ---------------------------------------------------------------------------
// single_pulse_of_verifla
// Rising-edge detector: turns a level that is synchronous to clk into a
// one-cycle pulse in the first cycle the level is seen high. A level held
// high for many cycles yields a single pulse.
// Ports:
//   clk    in  system clock
//   rst_l  in  asynchronous active-low reset
//   level  in  level to watch
//   pulse  out high for the first cycle of each high period of level
// ---------------------------------------------------------------------------
module single_pulse_of_verifla (
   input  logic clk,
   input  logic rst_l,
   input  logic level,
   output logic pulse
);

   logic level_q;

   // Remember last cycle's level so a new high period can be told apart
   // from one that is continuing
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/command_decoder_of_verifla.sv
// ---------------------------------------------------------------------------
// command_decoder_of_verifla
// Multi-byte host command decoder. Bytes from the UART receiver are decoded
// as opcodes: RESET and RUN produce one-cycle control pulses, WRITE_REG opens
// a frame of one address byte followed by DATA_BYTES little-endian data bytes
// that is delivered to the config bank with a single cfg_wr strobe. A frame
// that stalls for too long between bytes is dropped and flagged.
// Parameters:
//   DATA_BYTES   data bytes per WRITE_REG frame (1..8)
//   ADDR_BITS    width of cfg_addr (<= 8, low bits of the address byte)
//   TIMEOUT_CYC  idle cycles tolerated between bytes of one frame (>= 2)
//   TO_BITS      timeout counter width, 2**TO_BITS > TIMEOUT_CYC
// Ports:
//   clk             in   system clock
//   rst_l           in   asynchronous active-low reset
//   rec_dataH       in   received byte, valid while rec_readyH is high
//   rec_readyH      in   byte-ready level from the UART
//   user_reset_low  out  one-cycle active-low reset pulse (opcode 0x00)
//   user_run        out  one-cycle run pulse (opcode 0x01)
//   cfg_wr          out  one-cycle write strobe at WRITE_REG completion
//   cfg_addr        out  register address, held until the next cfg_wr
//   cfg_data        out  register data, held until the next cfg_wr
//   cmd_error       out  one-cycle pulse on unknown opcode or frame timeout
//   busy            out  high while a WRITE_REG frame is being collected
// ---------------------------------------------------------------------------
module command_decoder_of_verifla
   import command_decoder_of_verifla_pkg::*;
#(
   parameter int DATA_BYTES  = 4,
   parameter int ADDR_BITS   = 8,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int TO_BITS     = 20
) (
   input  logic                    clk,
   input  logic                    rst_l,
   input  logic [7:0]              rec_dataH,
   input  logic                    rec_readyH,
   output logic                    user_reset_low,
   output logic                    user_run,
   output logic                    cfg_wr,
   output logic [ADDR_BITS-1:0]    cfg_addr,
   output logic [8*DATA_BYTES-1:0] cfg_data,
   output logic                    cmd_error,
   output logic                    busy
);

   localparam int                  BC_BITS   = byte_cnt_bits(DATA_BYTES);
   localparam int                  DW        = 8 * DATA_BYTES;
   localparam logic [BC_BITS-1:0]  LAST_BYTE = BC_BITS'(DATA_BYTES - 1);
   localparam logic [TO_BITS-1:0]  TO_LIMIT  = TO_BITS'(TIMEOUT_CYC - 1);

   dec_state_t           state_q, state_d;
   logic [BC_BITS-1:0]   byte_cnt_q, byte_cnt_d;
   logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;
   logic [ADDR_BITS-1:0] addr_sh_q, addr_sh_d;
   logic [DW-1:0]        data_sh_q, data_sh_d;
   logic [ADDR_BITS-1:0] cfg_addr_d;
   logic [DW-1:0]        cfg_data_d;
   logic                 user_reset_low_d;
   logic                 user_run_d;
   logic                 cfg_wr_d;
   logic                 cmd_error_d;
   logic                 busy_d;
   logic                 byte_accept;
   logic                 timed_out;

   // One accept per rising edge of the UART ready level
   single_pulse_of_verifla u_ready_edge (
      .clk   (clk),
      .rst_l (rst_l),
      .level (rec_readyH),
      .pulse (byte_accept)
   );

   // A byte landing in the last allowed cycle beats the timeout
   assign timed_out = (to_cnt_q == TO_LIMIT) && !byte_accept;

   // Next-state and next-output logic. Everything leaving the block is a
   // register, so this computes what each register holds next cycle. The
   // address/data shadows collect a frame so the visible cfg outputs only
   // change once a frame is complete.
   always_comb begin
      state_d          = state_q;
      byte_cnt_d       = byte_cnt_q;
      to_cnt_d         = '0;
      addr_sh_d        = addr_sh_q;
      data_sh_d        = data_sh_q;
      cfg_addr_d       = cfg_addr;
      cfg_data_d       = cfg_data;
      user_reset_low_d = 1'b1;
      user_run_d       = 1'b0;
      cfg_wr_d         = 1'b0;
      cmd_error_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (byte_accept) begin
               unique case (rec_dataH)
                  CMD_RESET:     user_reset_low_d = 1'b0;
                  CMD_RUN:       user_run_d       = 1'b1;
                  CMD_WRITE_REG: state_d          = GET_ADDR;
                  default:       cmd_error_d      = 1'b1;
               endcase
            end
         end

         GET_ADDR: begin
            if (byte_accept) begin
               addr_sh_d  = rec_dataH[ADDR_BITS-1:0];
               byte_cnt_d = '0;
               state_d    = GET_DATA;
            end else if (timed_out) begin
               cmd_error_d = 1'b1;
               state_d     = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         GET_DATA: begin
            if (byte_accept) begin
               data_sh_d[int'(byte_cnt_q)*8 +: 8] = rec_dataH;
               if (byte_cnt_q == LAST_BYTE) begin
                  cfg_wr_d   = 1'b1;
                  cfg_addr_d = addr_sh_q;
                  cfg_data_d = data_sh_d;
                  state_d    = IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (timed_out) begin
               cmd_error_d = 1'b1;
               state_d     = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, counters, shadows and all outputs are registered together;
   // reset drops any partial frame
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q        <= IDLE;
         byte_cnt_q     <= '0;
         to_cnt_q       <= '0;
         addr_sh_q      <= '0;
         data_sh_q      <= '0;
         cfg_addr       <= '0;
         cfg_data       <= '0;
         user_reset_low <= 1'b1;
         user_run       <= 1'b0;
         cfg_wr         <= 1'b0;
         cmd_error      <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_q        <= state_d;
         byte_cnt_q     <= byte_cnt_d;
         to_cnt_q       <= to_cnt_d;
         addr_sh_q      <= addr_sh_d;
         data_sh_q      <= data_sh_d;
         cfg_addr       <= cfg_addr_d;
         cfg_data       <= cfg_data_d;
         user_reset_low <= user_reset_low_d;
         user_run       <= user_run_d;
         cfg_wr         <= cfg_wr_d;
         cmd_error      <= cmd_error_d;
         busy           <= busy_d;
      end
   end

endmodule

// File: tb/tb_command_decoder_of_verifla.sv
// ---------------------------------------------------------------------------
// tb_command_decoder_of_verifla
// Bench for the host command decoder with a short timeout. A byte-level
// model predicts each control pulse (with its cycle) and the busy/cfg
// levels; a monitor compares them against the decoder every cycle.
// ---------------------------------------------------------------------------
module tb_command_decoder_of_verifla;

   localparam int DB = 4;
   localparam int T  = 50;

   localparam logic [3:0] K_RST = 4'b1000;
   localparam logic [3:0] K_RUN = 4'b0100;
   localparam logic [3:0] K_WR  = 4'b0010;
   localparam logic [3:0] K_ERR = 4'b0001;

   typedef struct {
      logic [3:0]  kind;
      int          cyc;
      logic [7:0]  addr;
      logic [31:0] data;
   } ev_t;

   logic        clk;
   logic        rst_l;
   logic [7:0]  rec_dataH;
   logic        rec_readyH;
   logic        user_reset_low;
   logic        user_run;
   logic        cfg_wr;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cmd_error;
   logic        busy;

   int          cyc;
   int          checks;
   int          passes;

   ev_t         sb[$];
   int          busy_change[int];
   logic [7:0]  frame_q[$];
   bit          in_frame;
   int          last_acc;

   logic        exp_busy;
   logic [7:0]  exp_addr;
   logic [31:0] exp_data;

   command_decoder_of_verifla #(
      .DATA_BYTES  (DB),
      .ADDR_BITS   (8),
      .TIMEOUT_CYC (T),
      .TO_BITS     (6)
   ) dut (
      .clk            (clk),
      .rst_l          (rst_l),
      .rec_dataH      (rec_dataH),
      .rec_readyH     (rec_readyH),
      .user_reset_low (user_reset_low),
      .user_run       (user_run),
      .cfg_wr         (cfg_wr),
      .cfg_addr       (cfg_addr),
      .cfg_data       (cfg_data),
      .cmd_error      (cmd_error),
      .busy           (busy)
   );

   // 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle number, read by driver and monitor away from the rising edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic pushEvent(input logic [3:0] kind, input int c, input logic [7:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   // Model: an open frame with no byte for more than T cycles after its last
   // byte is dropped; the error shows T+1 cycles after that byte
   task automatic resolveTimeout(input int c);
      if (in_frame && c > last_acc + T) begin
         pushEvent(K_ERR, last_acc + T + 1, 8'h00, 32'h0);
         busy_change[last_acc + T + 1] = 0;
         in_frame = 0;
      end
   endtask

   // Model: one byte accepted in cycle c, results visible in cycle c+1
   task automatic modelByte(input logic [7:0] b, input int c);
      logic [31:0] d;
      resolveTimeout(c);
      if (!in_frame) begin
         case (b)
            8'h00: pushEvent(K_RST, c + 1, 8'h00, 32'h0);
            8'h01: pushEvent(K_RUN, c + 1, 8'h00, 32'h0);
            8'h02: begin
               in_frame = 1;
               frame_q.delete();
               busy_change[c + 1] = 1;
            end
            default: pushEvent(K_ERR, c + 1, 8'h00, 32'h0);
         endcase
      end else begin
         frame_q.push_back(b);
         if (frame_q.size() == 1 + DB) begin
            d = 32'h0;
            for (int k = 0; k < DB; k++) d = d | (32'(frame_q[k + 1]) << (8 * k));
            pushEvent(K_WR, c + 1, frame_q[0], d);
            busy_change[c + 1] = 0;
            in_frame = 0;
         end
      end
      last_acc = c;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Send one byte after gap cycles of low ready, holding ready for hold cycles
   task automatic applyStimulus(input logic [7:0] b, input int gap, input int hold);
      modelByte(b, cyc + gap);
      repeat (gap) step();
      rec_dataH  = b;
      rec_readyH = 1'b1;
      repeat (hold) step();
      rec_readyH = 1'b0;
      rec_dataH  = $urandom_range(0, 255);
   endtask

   task automatic idleFor(input int n);
      resolveTimeout(cyc + n);
      repeat (n) step();
   endtask

   task automatic doReset();
      step();
      resolveTimeout(cyc);
      rst_l      = 1'b0;
      rec_readyH = 1'b0;
      in_frame   = 0;
      frame_q.delete();
      busy_change.delete();
      step();
      checkOutput("reset_values",
                  {19'h0, user_reset_low, user_run, cfg_wr, cmd_error, busy, cfg_addr, cfg_data},
                  {19'h0, 1'b1, 4'b0000, 8'h00, 32'h0});
      step();
      rst_l = 1'b1;
   endtask

   function automatic int randGap(input int hold);
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) return T - hold;
      if (r == 1) return T - hold + 1;
      return $urandom_range(1, 4);
   endfunction

   // Monitor: each cycle, pop expected pulses that are due, compare any
   // pulse the decoder shows, then compare busy and the held cfg outputs
   always @(negedge clk) begin
      logic [3:0] act_kind;
      ev_t        e;
      if (!rst_l) begin
         exp_busy = 1'b0;
         exp_addr = 8'h00;
         exp_data = 32'h0;
      end else begin
         if (busy_change.exists(cyc)) exp_busy = busy_change[cyc][0];
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checkOutput("missed_pulse", 64'(cyc), 64'(e.cyc));
         end
         act_kind = {~user_reset_low, user_run, cfg_wr, cmd_error};
         if (act_kind != 4'b0000) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_pulse", 64'(act_kind), 64'h0);
            end else begin
               e = sb.pop_front();
               checkOutput("pulse_kind", 64'(act_kind), 64'(e.kind));
               checkOutput("pulse_cycle", 64'(cyc), 64'(e.cyc));
               if (e.kind == K_WR) begin
                  exp_addr = e.addr;
                  exp_data = e.data;
               end
            end
         end
         checkOutput("busy_cfg", {23'h0, busy, cfg_addr, cfg_data}, {23'h0, exp_busy, exp_addr, exp_data});
      end
   end

   // Stimulus: directed scenarios, then a randomized command mix
   initial begin
      int op;
      int hold;
      int n;
      cyc        = 0;
      checks     = 0;
      passes     = 0;
      in_frame   = 0;
      last_acc   = 0;
      rst_l      = 1'b0;
      rec_readyH = 1'b0;
      rec_dataH  = 8'h00;
      step();
      step();
      checkOutput("reset_values",
                  {19'h0, user_reset_low, user_run, cfg_wr, cmd_error, busy, cfg_addr, cfg_data},
                  {19'h0, 1'b1, 4'b0000, 8'h00, 32'h0});
      rst_l = 1'b1;
      step();

      $display("[TB] reset and run opcodes");
      applyStimulus(8'h00, 2, 1);
      applyStimulus(8'h01, 3, 2);

      $display("[TB] write frame");
      applyStimulus(8'h02, 2, 1);
      applyStimulus(8'h05, 1, 1);
      applyStimulus(8'hEF, 2, 1);
      applyStimulus(8'hBE, 1, 3);
      applyStimulus(8'hAD, 4, 1);
      applyStimulus(8'hDE, 1, 1);

      $display("[TB] unknown opcode then recovery");
      applyStimulus(8'h7F, 3, 1);
      applyStimulus(8'h01, 2, 1);

      $display("[TB] frame timeout");
      applyStimulus(8'h02, 2, 1);
      applyStimulus(8'h05, 1, 1);
      applyStimulus(8'hAA, 1, 1);
      idleFor(60);
      applyStimulus(8'h01, 2, 1);

      $display("[TB] bytes in the last allowed cycle");
      applyStimulus(8'h02, 2, 1);
      applyStimulus(8'h33, T - 1, 1);
      applyStimulus(8'h44, T - 1, 1);
      applyStimulus(8'h55, T - 1, 1);
      applyStimulus(8'h66, T - 1, 1);
      applyStimulus(8'h77, T - 1, 1);

      $display("[TB] reset mid-frame and held ready level");
      applyStimulus(8'h02, 2, 1);
      applyStimulus(8'h05, 1, 1);
      applyStimulus(8'h11, 1, 1);
      doReset();
      applyStimulus(8'h01, 2, 10);

      $display("[TB] randomized command mix");
      for (int i = 0; i < 60; i++) begin
         op   = $urandom_range(0, 9);
         hold = $urandom_range(1, 3);
         case (op)
            0: applyStimulus(8'h00, randGap(hold), hold);
            1: applyStimulus(8'h01, randGap(hold), hold);
            2, 3: applyStimulus(8'($urandom_range(3, 255)), randGap(hold), hold);
            4, 5, 6, 7: begin
               applyStimulus(8'h02, $urandom_range(1, 4), hold);
               for (int k = 0; k <= DB; k++) begin
                  hold = $urandom_range(1, 3);
                  applyStimulus(8'($urandom_range(0, 255)), randGap(hold), hold);
               end
            end
            8: begin
               applyStimulus(8'h02, $urandom_range(1, 4), hold);
               n = $urandom_range(0, DB);
               for (int k = 0; k < n; k++) applyStimulus(8'($urandom_range(0, 255)), $urandom_range(1, 4), 1);
            end
            default: doReset();
         endcase
      end

      idleFor(T + 5);
      checkOutput("scoreboard_drain", 64'(sb.size()), 64'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Bound on total run time
   initial begin
      #500000;
      checkOutput("watchdog", 64'h1, 64'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
